oai221_zn_event_monitor: RTL

- Sequential consumer placed directly downstream of an OAI221_X1 output (ZN = !((C1|C2) & (B1|B2) & A)).
- ZN idles high; the monitor treats a low-going ZN as an event.
- It synchronises ZN into the CK domain, deglitches it with a stability filter, and counts qualified falling events.
- Events are presented to a consumer over a valid/ready handshake. Used as a condition monitor next to standard-cell logic blocks.

---
 rtl/oai221_zn_event_monitor_pkg.sv | 24 ++
 rtl/oai221_zn_event_monitor_if.sv | 24 ++
 rtl/oai221_zn_event_monitor_sync_filter.sv | 109 ++++++++++
 rtl/oai221_zn_event_monitor.sv | 64 ++++++
 4 files changed

// File: rtl/oai221_zn_event_monitor_pkg.sv
// Shared types and constants for the OAI221 ZN event monitor.
// The filter state encoding and sizing helper are used by both the filter and the top level.
package oai221_zn_event_monitor_pkg;

   typedef enum logic [1:0] {
      ST_HI      = 2'd0,
      ST_QUAL_LO = 2'd1,
      ST_LO      = 2'd2,
      ST_QUAL_HI = 2'd3
   } filt_state_e;

   // ZN of an idle OAI221 sits high; a low level is the condition being watched.
   localparam logic ZN_IDLE = 1'b1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/oai221_zn_event_monitor_if.sv
// Event handshake bundle: pending flag, acknowledge, saturating count and overflow.
// The monitor drives through 'master', the consumer through 'slave'.
interface oai221_zn_event_monitor_if #(
   parameter int CNT_W = 8
);
   logic             EVT_VALID;
   logic             EVT_READY;
   logic [CNT_W-1:0] EVT_COUNT;
   logic             OVF;

   modport master (
      output EVT_VALID,
      output EVT_COUNT,
      output OVF,
      input  EVT_READY
   );

   modport slave (
      input  EVT_VALID,
      input  EVT_COUNT,
      input  OVF,
      output EVT_READY
   );
endinterface

// File: rtl/oai221_zn_event_monitor_sync_filter.sv
// Synchroniser plus four-state stability filter for the asynchronous ZN input.
// o_fall_evt is high for the single cycle in which the filtered level is about to go low.
module oai221_zn_sync_filter
   import oai221_zn_event_monitor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_zn,
   input  logic i_en,
   output logic o_filt,
   output logic o_fall_evt
);

   localparam int              QW     = clog2(FILT_LEN + 1);
   localparam logic [QW-1:0]   Q_LAST = QW'(FILT_LEN - 1);
   localparam logic [QW-1:0]   Q_ONE  = QW'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   filt_state_e            r_state;
   logic [QW-1:0]          r_q;
   logic                   r_filt;
   logic                   w_s;

   // Sync chain runs independently of EN so the sample is always current.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {SYNC_STAGES{ZN_IDLE}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_zn};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_HI;
         r_q     <= '0;
         r_filt  <= ZN_IDLE;
      end else if (!i_en) begin
         r_q <= '0;
      end else begin
         unique case (r_state)
            ST_HI: begin
               if (!w_s) begin
                  if (FILT_LEN == 1) begin
                     r_state <= ST_LO;
                     r_filt  <= 1'b0;
                  end else begin
                     r_state <= ST_QUAL_LO;
                     r_q     <= Q_ONE;
                  end
               end
            end
            ST_QUAL_LO: begin
               if (w_s) begin
                  r_state <= ST_HI;
                  r_q     <= '0;
               end else if (r_q == Q_LAST) begin
                  r_state <= ST_LO;
                  r_q     <= '0;
                  r_filt  <= 1'b0;
               end else begin
                  r_q <= r_q + Q_ONE;
               end
            end
            ST_LO: begin
               if (w_s) begin
                  if (FILT_LEN == 1) begin
                     r_state <= ST_HI;
                     r_filt  <= 1'b1;
                  end else begin
                     r_state <= ST_QUAL_HI;
                     r_q     <= Q_ONE;
                  end
               end
            end
            ST_QUAL_HI: begin
               if (!w_s) begin
                  r_state <= ST_LO;
                  r_q     <= '0;
               end else if (r_q == Q_LAST) begin
                  r_state <= ST_HI;
                  r_q     <= '0;
                  r_filt  <= 1'b1;
               end else begin
                  r_q <= r_q + Q_ONE;
               end
            end
            default: begin
               r_state <= ST_HI;
               r_q     <= '0;
            end
         endcase
      end
   end

   // Decoded from the same terms that move the FSM into LO, so the top level can
   // update its registers on the very edge at which o_filt falls.
   assign o_fall_evt = i_en && !w_s &&
                       (((r_state == ST_QUAL_LO) && (r_q == Q_LAST)) ||
                        ((FILT_LEN == 1) && (r_state == ST_HI)));

   assign o_filt = r_filt;

endmodule

// File: rtl/oai221_zn_event_monitor.sv
// Condition monitor for an OAI221 ZN output: filters ZN, counts qualified falling
// events with saturation/overflow, and flags pending events over a valid/ready handshake.
module oai221_zn_event_monitor
   import oai221_zn_event_monitor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int CNT_W       = 8
) (
   input  logic CK,
   input  logic RST,
   input  logic ZN_IN,
   input  logic EN,
   input  logic CLR,
   output logic FILT_OUT,
   oai221_zn_event_monitor_if.master evt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             w_fall_evt;
   logic             w_filt;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_valid;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   oai221_zn_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_sync_filter (
      .i_clk      (CK),
      .i_rst      (RST),
      .i_zn       (ZN_IN),
      .i_en       (EN),
      .o_filt     (w_filt),
      .o_fall_evt (w_fall_evt)
   );

   // A new event outranks a same-cycle transfer so a pending flag is never lost;
   // CLR outranks both and discards any coinciding event.
   always_ff @(posedge CK) begin
      if (RST || CLR) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_fall_evt) begin
         r_count <= sat_inc(r_count);
         r_valid <= 1'b1;
         if (r_count == CNT_MAX) r_ovf <= 1'b1;
      end else if (r_valid && evt.EVT_READY) begin
         r_valid <= 1'b0;
      end
   end

   assign FILT_OUT      = w_filt;
   assign evt.EVT_VALID = r_valid;
   assign evt.EVT_COUNT = r_count;
   assign evt.OVF       = r_ovf;

endmodule
